sdram_port_arbiter: RTL and testbench
=====================================

// Module: sdram_port_arbiter
// PURPOSE
// - Shares one sdram controller request/response interface among N_PORTS requesters.
//   Examples: capture DMA, USB readback, CPU.
// - Round-robin grant on the request channel.
// - In-order tag FIFO routes each response (bvalid/bwe/bdata) back to the port that issued it.
// - Sits between the requesters and the sdram controller's avalid/aready/b* interface.
// PARAMETERS
// - N_PORTS    2  number of requesters, 2..8
// - TAG_DEPTH  8  outstanding-request capacity (power of 2); bounds in-flight reads+writes
// - MAX_BURST  8  max consecutive same-row grants to one port (only with SDRAM_ARB_BURST_LOCK_EN)
// PORTS
// - rst        in   1          reset, asynchronous, active-high
// - clk        in   1          clock
// - p_valid    in   N          per-port request valid
// - p_ready    out  N          per-port request accepted this cycle
// - p_we       in   N          per-port write(1)/read(0)
// - p_addr     in   N*24       per-port word address, port i at [24*i+:24]
// - p_data     in   N*16       per-port write data, port i at [16*i+:16]
// - p_bvalid   out  N          per-port response strobe
// - p_bwe      out  1          response type, shared by all ports
// - p_bdata    out  16         read data, shared by all ports
// - s_valid    out  1          to controller avalid
// - s_ready    in   1          from controller aready
// - s_we       out  1          to controller awe
// - s_addr     out  24         to controller aaddr
// - s_data     out  16         to controller adata
// - s_bvalid   in   1          from controller bvalid
// - s_bwe      in   1          from controller bwe
// - s_bdata    in   16         from controller bdata
// - err        out  1          sticky: response arrived with tag FIFO empty
// BEHAVIOUR
// - Reset:
//   - p_ready=0, p_bvalid=0, s_valid=0, err=0.
//   - Tag FIFO empty; rr pointer=0.
//   - p_bwe/p_bdata/s_we/s_addr/s_data are don't-care.
// - Grant (combinational):
//   - Search starts at rr pointer and wraps; the first port with p_valid=1 is granted.
//   - s_valid = |p_valid && !tag_full.
//   - s_* mux the granted port's fields.
//   - s_valid never depends on s_ready.
// - Handshake:
//   - p_ready[g] = s_valid && s_ready. It is zero for all other ports.
//   - On handshake, the port index is pushed into the tag FIFO.
//   - On handshake, rr <= (g+1) mod N_PORTS.
// - Response:
//   - On s_bvalid, pop the tag FIFO and set p_bvalid[tag]=1 in the same cycle (combinational, zero added latency).
//   - p_bwe=s_bwe, p_bdata=s_bdata.
// - Ordering: the controller returns responses strictly in request order (writes and reads alike), so a FIFO is sufficient.
// - Full: when count==TAG_DEPTH, s_valid=0 even if requests are pending. A pop in the same cycle does not unblock until the next cycle.
// - Simultaneous push+pop: count unchanged; pointers both advance.
// - Empty + s_bvalid:
//   - No p_bvalid is asserted.
//   - err <= 1 and stays 1 until reset.
//   - Count stays 0; no underflow.
// - Counters: count is clog2(TAG_DEPTH)+1 bits; rd/wr pointers are clog2(TAG_DEPTH) bits with natural wrap.
// - A port must hold p_valid and its fields stable until p_ready. The arbiter never drops or reorders a port's own requests.
// - Reset mid-operation clears all in-flight tags. The controller shares rst, so no stale responses arrive.
// CONFIGURATION
// - SDRAM_ARB_BURST_LOCK_EN defined:
//   - After a grant to port g, the grant stays locked to g while p_valid[g]=1.
//   - Lock also requires p_addr[g][23:9] (bank+row) to equal the last accepted address's [23:9].
//   - Lock also requires burst_cnt < MAX_BURST.
//   - While locked, rr does not advance. The lock releases on any violation, and rr <= g+1.
//   - burst_cnt resets to 1 on each new grant.
// - Not defined: pure round-robin per accepted request; no burst_cnt or row register is synthesized.
// STRUCTURE
// - sdram_pkg: ADDR_W=24, DATA_W=16, ROW_LSB=9 (bank+row field start), function clog2_min1.
// - Sub-module sdram_tag_fifo: width clog2(N_PORTS), depth TAG_DEPTH.
//   - Interface: push/pop/din/dout/full/empty/count.
//   - Show-ahead dout.
// - The top level holds the rr grant logic, the mux and the burst lock.
// TESTING
// - Reset: all p_ready/p_bvalid/s_valid=0, err=0. Requests held during rst are never granted.
// - Ports 0,1 both valid continuously, s_ready=1, macro off:
//   - s_addr alternates port0/port1 each cycle, 0x000100, 0x800200, ...
//   - Tags recorded in order.
// - Port1 read @0x000010, then port0 write @0x000020:
//   - Delayed s_bvalid responses route to p_bvalid[1] with bdata=0xBEEF, then p_bvalid[0] with bwe=1.
// - Hold s_bvalid=0 with TAG_DEPTH=8:
//   - Exactly 8 handshakes, then s_valid=0.
//   - One s_bvalid, then one cycle later s_valid=1 again.
// - s_bvalid with FIFO empty: err=1 sticky, no p_bvalid, count stays 0.
// - SDRAM_ARB_BURST_LOCK_EN, MAX_BURST=4, port0 streaming same row, port1 valid:
//   - 4 port0 grants, then port1.
//   - A row change on port0 releases the lock immediately.

Source files
------------

// File: rtl/sdram_pkg.sv
// sdram_pkg: shared widths and sizing helper for the sdram port arbiter
package sdram_pkg;
    localparam int ADDR_W  = 24;
    localparam int DATA_W  = 16;
    localparam int ROW_LSB = 9;
    function automatic int clog2_min1(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/sdram_port_arbiter_if.sv
// sdram_port_arbiter_if: requester-side and controller-side signals of the sdram port arbiter
interface sdram_port_arbiter_if #(parameter int N_PORTS = 2);
    localparam int AW = sdram_pkg::ADDR_W;
    localparam int DW = sdram_pkg::DATA_W;
    logic [N_PORTS-1:0]    p_valid, p_ready, p_we, p_bvalid;
    logic [N_PORTS*AW-1:0] p_addr;
    logic [N_PORTS*DW-1:0] p_data;
    logic                  p_bwe;
    logic [DW-1:0]         p_bdata;
    logic                  s_valid, s_ready, s_we;
    logic [AW-1:0]         s_addr;
    logic [DW-1:0]         s_data;
    logic                  s_bvalid, s_bwe;
    logic [DW-1:0]         s_bdata;
    logic                  err;
    modport slave (
        input  p_valid, p_we, p_addr, p_data, s_ready, s_bvalid, s_bwe, s_bdata,
        output p_ready, p_bvalid, p_bwe, p_bdata, s_valid, s_we, s_addr, s_data, err
    );
    modport master (
        output p_valid, p_we, p_addr, p_data, s_ready, s_bvalid, s_bwe, s_bdata,
        input  p_ready, p_bvalid, p_bwe, p_bdata, s_valid, s_we, s_addr, s_data, err
    );
endinterface

// File: rtl/sdram_tag_fifo.sv
// sdram_tag_fifo: show-ahead FIFO of port tags, one per request in flight
module sdram_tag_fifo
    import sdram_pkg::*;
#(
    parameter int W     = 1,
    parameter int DEPTH = 8,
    localparam int AW   = clog2_min1(DEPTH)
)(
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o,
    output logic [AW:0]  count_o
);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_q, wr_q;
    logic [AW:0]   count_q;
    always_ff @(posedge clk)
        if (push_i) mem_q[wr_q] <= din_i;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + 1'b1;
            if (pop_i) rd_q <= rd_q + 1'b1;
            count_q <= count_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
        end
    assign dout_o  = mem_q[rd_q];
    assign full_o  = count_q == (AW+1)'(DEPTH);
    assign empty_o = count_q == '0;
    assign count_o = count_q;
endmodule

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: round-robin sharing of one sdram controller port, responses routed by tag FIFO
// SDRAM_ARB_BURST_LOCK_EN keeps the grant on a port streaming within one bank+row
module sdram_port_arbiter
    import sdram_pkg::*;
#(
    parameter int N_PORTS   = 2,
    parameter int TAG_DEPTH = 8,
    parameter int MAX_BURST = 8
)(
    input logic clk,
    input logic rst,
    sdram_port_arbiter_if.slave bus
);
    localparam int TW = clog2_min1(N_PORTS);
    localparam int CW = clog2_min1(TAG_DEPTH) + 1;
    logic [TW-1:0]      rr_q, rr_d, rr_gnt, gnt, tag;
    logic [N_PORTS-1:0] rot;
    logic [CW-1:0]      count;
    logic               full, empty, hs, pop, lock, err_q;
    // rot[k] is the request of port (rr+k) mod N, so the lowest set bit wins
    always_comb begin
        rot    = N_PORTS'({bus.p_valid, bus.p_valid} >> rr_q);
        rr_gnt = rr_q;
        for (int k = N_PORTS - 1; k >= 0; k--)
            if (rot[k]) rr_gnt = TW'((int'(rr_q) + k) % N_PORTS);
    end
`ifdef SDRAM_ARB_BURST_LOCK_EN
    localparam int RW = ADDR_W - ROW_LSB;
    localparam int BW = clog2_min1(MAX_BURST + 1);
    logic          have_q;
    logic [TW-1:0] last_q;
    logic [RW-1:0] row_q;
    logic [BW-1:0] burst_q;
    assign lock = have_q && bus.p_valid[last_q] && burst_q < BW'(MAX_BURST)
                  && bus.p_addr[int'(last_q)*ADDR_W+ROW_LSB +: RW] == row_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            have_q  <= 1'b0;
            last_q  <= '0;
            row_q   <= '0;
            burst_q <= '0;
        end else if (hs) begin
            have_q  <= 1'b1;
            last_q  <= gnt;
            row_q   <= bus.s_addr[ADDR_W-1:ROW_LSB];
            burst_q <= lock ? burst_q + 1'b1 : BW'(1);
        end
    assign gnt = lock ? last_q : rr_gnt;
`else
    logic unused_burst;
    assign unused_burst = ^MAX_BURST;
    assign lock = 1'b0;
    assign gnt  = rr_gnt;
`endif
    assign bus.s_valid  = |bus.p_valid && !full && !rst;
    assign hs           = bus.s_valid && bus.s_ready;
    assign pop          = bus.s_bvalid && !empty;
    assign bus.p_ready  = hs ? (N_PORTS'(1) << gnt) : '0;
    assign bus.p_bvalid = pop ? (N_PORTS'(1) << tag) : '0;
    assign bus.s_we     = bus.p_we[gnt];
    assign bus.s_addr   = bus.p_addr[int'(gnt)*ADDR_W +: ADDR_W];
    assign bus.s_data   = bus.p_data[int'(gnt)*DATA_W +: DATA_W];
    assign bus.p_bwe    = bus.s_bwe;
    assign bus.p_bdata  = bus.s_bdata;
    assign bus.err      = err_q;
    assign rr_d = (hs && !lock) ? ((gnt == TW'(N_PORTS - 1)) ? '0 : gnt + 1'b1) : rr_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            rr_q  <= '0;
            err_q <= 1'b0;
        end else begin
            rr_q  <= rr_d;
            err_q <= err_q | (bus.s_bvalid && count == '0);
        end
    sdram_tag_fifo #(.W(TW), .DEPTH(TAG_DEPTH)) u_tags (
        .clk(clk), .rst(rst), .push_i(hs), .pop_i(pop), .din_i(gnt),
        .dout_o(tag), .full_o(full), .empty_o(empty), .count_o(count)
    );
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter: vector table, directed corner cases and a queue-based random model
module tb_sdram_port_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_pass = 0;
    always #5 clk = ~clk;
    sdram_port_arbiter_if #(.N_PORTS(2)) bus ();
    sdram_port_arbiter #(.N_PORTS(2), .TAG_DEPTH(8), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    typedef struct {
        logic [1:0]  pv;
        logic        rdy;
        logic        bv;
        logic        sv;
        logic [1:0]  pr;
        logic [1:0]  pb;
        logic [23:0] addr;
    } vec_t;
    vec_t tbl[10];
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic settle();
        #3;
    endtask
    task automatic drive(input logic [1:0] pv, input logic rdy, input logic bv);
        bus.p_valid  = pv;
        bus.s_ready  = rdy;
        bus.s_bvalid = bv;
    endtask
    task automatic do_reset();
        drive(2'b00, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask
    initial begin
        rst = 1'b1;
        bus.p_we = 2'b00;
        bus.p_addr = {24'h800200, 24'h000100};
        bus.p_data = {16'h2222, 16'h1111};
        bus.s_bwe = 1'b0;
        bus.s_bdata = 16'h0;
        drive(2'b11, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("rst_svalid", bus.s_valid, 0);
            chk("rst_pready", bus.p_ready, 0);
            chk("rst_pbvalid", bus.p_bvalid, 0);
            chk("rst_err", bus.err, 0);
            tick();
        end
        rst = 1'b0;
`ifndef SDRAM_ARB_BURST_LOCK_EN
        tbl[0] = '{2'b11, 1'b1, 1'b0, 1'b1, 2'b01, 2'b00, 24'h000100};
        tbl[1] = '{2'b11, 1'b1, 1'b0, 1'b1, 2'b10, 2'b00, 24'h800200};
        tbl[2] = '{2'b11, 1'b1, 1'b0, 1'b1, 2'b01, 2'b00, 24'h000100};
        tbl[3] = '{2'b11, 1'b1, 1'b1, 1'b1, 2'b10, 2'b01, 24'h800200};
        tbl[4] = '{2'b00, 1'b1, 1'b1, 1'b0, 2'b00, 2'b10, 24'h0};
        tbl[5] = '{2'b00, 1'b1, 1'b1, 1'b0, 2'b00, 2'b01, 24'h0};
        tbl[6] = '{2'b00, 1'b1, 1'b1, 1'b0, 2'b00, 2'b10, 24'h0};
        tbl[7] = '{2'b10, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 24'h800200};
        tbl[8] = '{2'b10, 1'b1, 1'b0, 1'b1, 2'b10, 2'b00, 24'h800200};
        tbl[9] = '{2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 2'b10, 24'h0};
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].pv, tbl[i].rdy, tbl[i].bv);
            settle();
            chk($sformatf("tbl%0d_svalid", i), bus.s_valid, tbl[i].sv);
            chk($sformatf("tbl%0d_pready", i), bus.p_ready, tbl[i].pr);
            chk($sformatf("tbl%0d_pbvalid", i), bus.p_bvalid, tbl[i].pb);
            if (tbl[i].sv) chk($sformatf("tbl%0d_saddr", i), bus.s_addr, tbl[i].addr);
            tick();
        end
`endif
        // port1 read then port0 write, responses routed back in order
        bus.p_addr = {24'h000010, 24'h000020};
        bus.p_we = 2'b01;
        bus.p_data = {16'h0000, 16'h1234};
        drive(2'b10, 1'b1, 1'b0);
        settle();
        chk("rt_pready1", bus.p_ready, 2'b10);
        chk("rt_saddr1", bus.s_addr, 24'h000010);
        chk("rt_swe1", bus.s_we, 0);
        tick();
        drive(2'b01, 1'b1, 1'b0);
        settle();
        chk("rt_pready0", bus.p_ready, 2'b01);
        chk("rt_swe0", bus.s_we, 1);
        chk("rt_sdata0", bus.s_data, 16'h1234);
        tick();
        drive(2'b00, 1'b0, 1'b0);
        tick();
        settle();
        chk("rt_idle", bus.p_bvalid, 0);
        tick();
        bus.s_bwe = 1'b0;
        bus.s_bdata = 16'hBEEF;
        drive(2'b00, 1'b0, 1'b1);
        settle();
        chk("rt_bvalid1", bus.p_bvalid, 2'b10);
        chk("rt_bdata1", bus.p_bdata, 16'hBEEF);
        chk("rt_bwe1", bus.p_bwe, 0);
        tick();
        bus.s_bwe = 1'b1;
        bus.s_bdata = 16'h0;
        settle();
        chk("rt_bvalid0", bus.p_bvalid, 2'b01);
        chk("rt_bwe0", bus.p_bwe, 1);
        tick();
        // fill all 8 tags, then one response unblocks only on the following cycle
        bus.p_addr = {24'h800200, 24'h000100};
        drive(2'b01, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            settle();
            chk($sformatf("full_hs%0d", i), bus.p_ready, 2'b01);
            tick();
        end
        settle();
        chk("full_svalid", bus.s_valid, 0);
        chk("full_pready", bus.p_ready, 0);
        tick();
        drive(2'b01, 1'b1, 1'b1);
        settle();
        chk("full_pop_svalid", bus.s_valid, 0);
        chk("full_pop_pbvalid", bus.p_bvalid, 2'b01);
        tick();
        drive(2'b01, 1'b1, 1'b0);
        settle();
        chk("full_reopen", bus.s_valid, 1);
        chk("full_reopen_pr", bus.p_ready, 2'b01);
        tick();
        drive(2'b00, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            settle();
            chk($sformatf("drain%0d", i), bus.p_bvalid, 2'b01);
            tick();
        end
        // response with no tag outstanding
        settle();
        chk("emp_pbvalid", bus.p_bvalid, 0);
        chk("emp_err_pre", bus.err, 0);
        tick();
        drive(2'b00, 1'b0, 1'b0);
        settle();
        chk("emp_err", bus.err, 1);
        tick();
        tick();
        drive(2'b00, 1'b0, 1'b1);
        settle();
        chk("emp_err_sticky", bus.err, 1);
        chk("emp_pbvalid2", bus.p_bvalid, 0);
        tick();
        drive(2'b10, 1'b1, 1'b0);
        settle();
        chk("emp_req", bus.p_ready, 2'b10);
        tick();
        drive(2'b00, 1'b0, 1'b1);
        settle();
        chk("emp_route", bus.p_bvalid, 2'b10);
        tick();
        settle();
        chk("emp_no_underflow", bus.p_bvalid, 0);
        chk("emp_err_end", bus.err, 1);
        tick();
`ifdef SDRAM_ARB_BURST_LOCK_EN
        begin
            logic [1:0] exp_g [5] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
            do_reset();
            drive(2'b11, 1'b1, 1'b0);
            for (int i = 0; i < 5; i++) begin
                settle();
                chk($sformatf("burst_g%0d", i), bus.p_ready, exp_g[i]);
                tick();
            end
            do_reset();
            drive(2'b11, 1'b1, 1'b0);
            for (int i = 0; i < 2; i++) begin
                settle();
                chk($sformatf("row_g%0d", i), bus.p_ready, 2'b01);
                tick();
            end
            bus.p_addr = {24'h800200, 24'h000300};
            settle();
            chk("row_change_g", bus.p_ready, 2'b10);
            chk("row_change_addr", bus.s_addr, 24'h800200);
            tick();
        end
`else
        begin
            int          q[$];
            int          rr = 0;
            int          eg;
            logic        err_m = 1'b0;
            logic [1:0]  pend = 2'b00;
            logic [23:0] a [2];
            logic [15:0] d [2];
            logic [1:0]  w;
            logic [1:0]  epb;
            logic        esv, ehs, bv;
            do_reset();
            w = 2'b00;
            for (int c = 0; c < 400; c++) begin
                for (int i = 0; i < 2; i++)
                    if (!pend[i] && $urandom_range(1, 0) == 1) begin
                        pend[i] = 1'b1;
                        a[i] = 24'($urandom);
                        d[i] = 16'($urandom);
                        w[i] = 1'($urandom);
                    end
                bv = (q.size() > 0) ? ($urandom_range(2, 0) == 0) : ($urandom_range(19, 0) == 0);
                bus.p_addr = {a[1], a[0]};
                bus.p_data = {d[1], d[0]};
                bus.p_we = w;
                bus.s_bwe = 1'($urandom);
                bus.s_bdata = 16'($urandom);
                drive(pend, $urandom_range(3, 0) != 0, bv);
                eg = -1;
                for (int k = 0; k < 2; k++)
                    if (eg < 0 && pend[(rr + k) % 2]) eg = (rr + k) % 2;
                esv = eg >= 0 && q.size() < 8;
                ehs = esv && bus.s_ready;
                epb = (bv && q.size() > 0) ? 2'(1 << q[0]) : 2'b00;
                settle();
                chk("rnd_svalid", bus.s_valid, esv);
                chk("rnd_pready", bus.p_ready, ehs ? 2'(1 << eg) : 2'b00);
                chk("rnd_pbvalid", bus.p_bvalid, epb);
                chk("rnd_err", bus.err, err_m);
                if (esv) begin
                    chk("rnd_saddr", bus.s_addr, a[eg]);
                    chk("rnd_sdata", bus.s_data, d[eg]);
                    chk("rnd_swe", bus.s_we, w[eg]);
                end
                if (bv) begin
                    chk("rnd_bdata", bus.p_bdata, bus.s_bdata);
                    if (q.size() > 0) void'(q.pop_front());
                    else err_m = 1'b1;
                end
                if (ehs) begin
                    q.push_back(eg);
                    rr = (eg + 1) % 2;
                    pend[eg] = 1'b0;
                end
                tick();
            end
        end
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
